// File: rtl/i2s_tx_ctrl.sv
// Avalon-MM controller for the I2S transmit path: register file, stereo-pair FIFO,
// clock-divider programming, and the IDLE/PRIME/RUN/DRAIN sequencer that feeds the core.
module i2s_tx_ctrl #(
  parameter int DW    = 24,
  parameter int DEPTH = 16,
  parameter int PRIME = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    avs_address,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic          avs_read,
  output logic [31:0]   avs_readdata,
  input  logic          frame_req,
  output logic [DW-1:0] data_left,
  output logic [DW-1:0] data_right,
  output logic          data_valid,
  output logic          core_en,
  output logic [15:0]   clk_div,
  output logic          irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                en_q, en_d;
  logic                low_en_q, low_en_d;
  logic                err_en_q, err_en_d;
  logic [7:0]          low_thr_q, low_thr_d;
  logic [15:0]         clkdiv_q, clkdiv_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;
  logic [DW-1:0]       txl_q, txl_d;
  logic [LW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]       dl_q, dl_d;
  logic [DW-1:0]       dr_q, dr_d;
  logic                dv_q, dv_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [2*DW-1:0]     fifo_mem_q [DEPTH];

  logic [LW-1:0]       level;
  logic [7:0]          level8;
  logic                full, empty, running;
  logic                wr_ctrl, wr_clkdiv, wr_status, wr_txl, wr_txr;
  logic                flush, push, pop, serve;
  logic [2*DW-1:0]     head;
  logic                unused_wd;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign level8    = 8'(level);
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign running   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign head      = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign unused_wd = ^avs_writedata;

  assign wr_ctrl   = avs_write && (avs_address == 3'd0);
  assign wr_clkdiv = avs_write && (avs_address == 3'd1);
  assign wr_status = avs_write && (avs_address == 3'd2);
  assign wr_txl    = avs_write && (avs_address == 3'd3);
  assign wr_txr    = avs_write && (avs_address == 3'd4);

  // FULL is judged on the registered level, so a same-cycle pop cannot rescue a push
  assign flush = wr_ctrl && avs_writedata[3];
  assign push  = wr_txr && !full;
  assign serve = frame_req && running;
  assign pop   = serve && !empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en_q) state_d = S_PRIME;
      S_PRIME: begin
        if (!en_q)                             state_d = S_IDLE;
        else if (32'(level) >= 32'(PRIME))     state_d = S_RUN;
      end
      S_RUN:   if (!en_q) state_d = S_DRAIN;
      S_DRAIN: if (frame_req && empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    low_en_d   = low_en_q;
    err_en_d   = err_en_q;
    low_thr_d  = low_thr_q;
    clkdiv_d   = clkdiv_q;
    txl_d      = txl_q;
    if (wr_ctrl) begin
      en_d      = avs_writedata[0];
      low_en_d  = avs_writedata[1];
      err_en_d  = avs_writedata[2];
      low_thr_d = avs_writedata[15:8];
    end
    if (wr_clkdiv) clkdiv_d = avs_writedata[15:0];
    if (wr_txl)    txl_d    = avs_writedata[DW-1:0];

    // W1C clears first so a same-cycle set event wins
    underrun_d = (underrun_q && !(wr_status && avs_writedata[0]))
               || (serve && empty && (state_q == S_RUN));
    overflow_d = (overflow_q && !(wr_status && avs_writedata[1]))
               || (wr_txr && full);

    wr_ptr_d = flush ? '0 : wr_ptr_q + LW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + LW'(pop);

    dl_d = dl_q;
    dr_d = dr_q;
    dv_d = serve;
    if (serve) begin
      dl_d = pop ? head[2*DW-1:DW] : '0;
      dr_d = pop ? head[DW-1:0]    : '0;
    end

    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        3'd0:    rdata_d = {16'h0, low_thr_q, 4'h0, 1'b0, err_en_q, low_en_q, en_q};
        3'd1:    rdata_d = {16'h0, clkdiv_q};
        3'd2:    rdata_d = {16'h0, level8, 3'b000, running, empty, full, overflow_q, underrun_q};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      low_en_q   <= 1'b0;
      err_en_q   <= 1'b0;
      low_thr_q  <= '0;
      clkdiv_q   <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      txl_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dl_q       <= '0;
      dr_q       <= '0;
      dv_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      low_en_q   <= low_en_d;
      err_en_q   <= err_en_d;
      low_thr_q  <= low_thr_d;
      clkdiv_q   <= clkdiv_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      txl_q      <= txl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dl_q       <= dl_d;
      dr_q       <= dr_d;
      dv_q       <= dv_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {txl_q, avs_writedata[DW-1:0]};
  end

  assign avs_readdata = rdata_q;
  assign data_left    = dl_q;
  assign data_right   = dr_q;
  assign data_valid   = dv_q;
  assign core_en      = running;
  assign clk_div      = clkdiv_q;
  assign irq          = (low_en_q && (level8 <= low_thr_q) && running)
                      || (err_en_q && (underrun_q || overflow_q));

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Scenario bench for i2s_tx_ctrl: a FIFO model feeds an expected-output queue that is
// drained whenever the DUT pulses data_valid.
module tb_i2s_tx_ctrl;
  localparam int DW = 24, DEPTH = 16, PRIME = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    avs_address = '0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_readdata;
  logic          frame_req = 1'b0;
  logic [DW-1:0] data_left, data_right;
  logic          data_valid, core_en, irq;
  logic [15:0]   clk_div;

  int n_chk = 0;
  int n_fail = 0;
  logic [47:0] model_q[$];
  logic [47:0] exp_q[$];

  i2s_tx_ctrl #(.DW(DW), .DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .frame_req(frame_req), .data_left(data_left), .data_right(data_right),
    .data_valid(data_valid), .core_en(core_en), .clk_div(clk_div), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk); avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); avs_address = a; avs_read = 1'b1;
    @(negedge clk); avs_read = 1'b0; d = avs_readdata;
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    avs_wr(3'd3, {8'h0, l});
    avs_wr(3'd4, {8'h0, r});
    if (model_q.size() < DEPTH) model_q.push_back({l, r});
  endtask

  // Scoreboard consumer: waits for data_valid and compares against the queue head
  task automatic collect(input string name);
    logic [47:0] e;
    bit seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (data_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'h0;
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: data_valid never seen, required pair %h", name, e);
    end else if ({data_left, data_right} !== e) begin
      n_fail++;
      $display("FAIL %s: pair got %h required %h", name, {data_left, data_right}, e);
    end
    @(negedge clk);
    n_chk++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: data_valid got %b required 0", name, data_valid);
    end
  endtask

  task automatic frame(input string name);
    @(negedge clk); frame_req = 1'b1;
    exp_q.push_back((model_q.size() > 0) ? model_q.pop_front() : 48'h0);
    @(negedge clk); frame_req = 1'b0;
    collect(name);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({core_en, data_valid, irq} !== 3'b000 || clk_div !== 16'h0 || avs_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b dv=%b irq=%b div=%h rd=%h required all 0",
               core_en, data_valid, irq, clk_div, avs_readdata);
    end
    reset_n = 1'b1;
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd !== 32'h8) begin n_fail++; $display("FAIL reset_status: got %h required 00000008", rd); end
    avs_rd(3'd0, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", rd); end
  endtask

  task automatic test_prime_start();
    logic [31:0] rd;
    avs_wr(3'd1, 32'd8);
    n_chk++;
    if (clk_div !== 16'd8) begin n_fail++; $display("FAIL clk_div: got %h required 0008", clk_div); end
    avs_rd(3'd1, rd);
    n_chk++;
    if (rd !== 32'd8) begin n_fail++; $display("FAIL clkdiv_read: got %h required 8", rd); end
    push_pair(24'h123456, 24'hABCDEF);
    avs_wr(3'd0, 32'h1);
    repeat (3) @(negedge clk);
    n_chk++;
    if (core_en !== 1'b0) begin n_fail++; $display("FAIL prime_hold: core_en got %b required 0", core_en); end
    push_pair(24'h654321, 24'h0FEDCB);
    n_chk++;
    if (core_en !== 1'b0) begin n_fail++; $display("FAIL prime_edge: core_en got %b required 0", core_en); end
    @(negedge clk);
    n_chk++;
    if (core_en !== 1'b1) begin n_fail++; $display("FAIL prime_start: core_en got %b required 1", core_en); end
    frame("first_pair");
    frame("second_pair");
  endtask

  task automatic test_underrun();
    logic [31:0] rd;
    avs_wr(3'd0, 32'h5);
    frame("underrun_zeros");
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd[0] !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b required 1", rd[0]); end
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL underrun_irq: got %b required 1", irq); end
    avs_wr(3'd2, 32'h1);
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL underrun_w1c_irq: got %b required 0", irq); end
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd[0] !== 1'b0) begin n_fail++; $display("FAIL underrun_w1c: got %b required 0", rd[0]); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    for (int i = 0; i < 17; i++) push_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd !== 32'h1016) begin n_fail++; $display("FAIL overflow_status: got %h required 00001016", rd); end
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL overflow_irq: got %b required 1", irq); end
    avs_wr(3'd2, 32'h2);
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd !== 32'h1014) begin n_fail++; $display("FAIL overflow_w1c: got %h required 00001014", rd); end
    for (int i = 0; i < 11; i++) frame("ovf_drain");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    avs_wr(3'd3, 32'h00AAAAAA);
    @(negedge clk);
    avs_address = 3'd4; avs_writedata = 32'h00555555; avs_write = 1'b1; frame_req = 1'b1;
    exp_q.push_back(model_q.pop_front());
    model_q.push_back({24'hAAAAAA, 24'h555555});
    @(negedge clk);
    avs_write = 1'b0; frame_req = 1'b0;
    collect("simul_pop");
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd[15:8] !== 8'd5) begin n_fail++; $display("FAIL simul_level: got %0d required 5", rd[15:8]); end
    for (int i = 0; i < 5; i++) frame("simul_order");
  endtask

  task automatic test_drain();
    logic [31:0] rd;
    push_pair(24'h000111, 24'h000222);
    push_pair(24'h000333, 24'h000444);
    push_pair(24'h000555, 24'h000666);
    avs_wr(3'd0, 32'h4);
    n_chk++;
    if (core_en !== 1'b1) begin n_fail++; $display("FAIL drain_en: core_en got %b required 1", core_en); end
    for (int i = 0; i < 3; i++) frame("drain_pair");
    frame("drain_zero");
    n_chk++;
    if (core_en !== 1'b0) begin n_fail++; $display("FAIL drain_stop: core_en got %b required 0", core_en); end
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd !== 32'h8) begin n_fail++; $display("FAIL drain_status: got %h required 00000008", rd); end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) push_pair(24'h0F0000 + 24'(i), 24'h0E0000 + 24'(i));
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd !== 32'h0300) begin n_fail++; $display("FAIL flush_pre: got %h required 00000300", rd); end
    avs_wr(3'd0, 32'h8);
    model_q.delete();
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd !== 32'h8) begin n_fail++; $display("FAIL flush_status: got %h required 00000008", rd); end
    avs_rd(3'd0, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL flush_selfclr: got %h required 0", rd); end
    avs_wr(3'd5, 32'hFFFFFFFF);
    avs_rd(3'd5, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL addr5: got %h required 0", rd); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    avs_wr(3'd0, 32'h0403);
    push_pair(24'h777777, 24'h888888);
    push_pair(24'h999999, 24'h111111);
    repeat (2) @(negedge clk);
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL low_irq: got %b required 1", irq); end
    frame_req = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_dv: got %b required 1", data_valid); end
    #1 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({core_en, data_valid, irq} !== 3'b000 || data_left !== '0 || data_right !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b dv=%b irq=%b dl=%h dr=%h required all 0",
               core_en, data_valid, irq, data_left, data_right);
    end
    frame_req = 1'b0;
    model_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    avs_rd(3'd2, rd);
    n_chk++;
    if (rd !== 32'h8) begin n_fail++; $display("FAIL post_reset_status: got %h required 00000008", rd); end
  endtask

  initial begin
    test_reset();
    test_prime_start();
    test_underrun();
    test_overflow();
    test_back_to_back();
    test_drain();
    test_flush();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
